// File: rtl/int16_to_fp16.sv
// 16-bit signed/unsigned integer to IEEE 754 half-precision converter, 3-stage pipeline.
// Define INT16_TO_FP16_ROUND_EN for round-to-nearest-even; default build truncates.
module int16_to_fp16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_inexact
);

  logic        en;
  logic        s1_valid;
  logic        s1_sign;
  logic [15:0] s1_mag;
  logic [3:0]  msb_idx;
  logic [14:0] norm;
  logic        s2_valid;
  logic        s2_sign;
  logic        s2_zero;
  logic [4:0]  s2_exp;
  logic [14:0] s2_norm;
  logic        guard;
  logic        sticky;
  logic        overflow;
  logic [9:0]  rnd_frac;
  logic [4:0]  rnd_exp;

  // One shared advance: the whole pipe, bubbles included, moves only when the output slot frees up.
  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sign  <= in_signed && in_data[15];
      s1_mag   <= (in_signed && in_data[15]) ? 16'(-in_data) : in_data;
    end
  end

  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (s1_mag[i]) msb_idx = 4'(i);
    end
  end

  // Left-justify so the leading 1 drops off the top; the remaining 15 bits are fraction, guard, sticky.
  assign norm = 15'(s1_mag << (4'd15 - msb_idx));

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_exp   <= '0;
      s2_norm  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= ~|s1_mag;
      s2_exp   <= 5'd15 + {1'b0, msb_idx};
      s2_norm  <= norm;
    end
  end

`ifdef INT16_TO_FP16_ROUND_EN
  logic carry;
`endif

  always_comb begin
    guard    = s2_norm[4];
    sticky   = |s2_norm[3:0];
    rnd_frac = s2_norm[14:5];
    rnd_exp  = s2_exp;
    overflow = 1'b0;
`ifdef INT16_TO_FP16_ROUND_EN
    {carry, rnd_frac} = {1'b0, s2_norm[14:5]} + 11'(guard && (sticky || s2_norm[5]));
    if (carry) rnd_exp = s2_exp + 5'd1;
    // Carry out of the top exponent lands on 31 with a zero fraction, which is exactly infinity.
    overflow = (rnd_exp == 5'd31);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_inexact <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_zero) begin
        out_data    <= '0;
        out_inexact <= 1'b0;
      end else begin
        out_data    <= {s2_sign, rnd_exp, rnd_frac};
        out_inexact <= guard || sticky || overflow;
      end
    end
  end

endmodule

// File: tb/tb_int16_to_fp16.sv
// Scoreboard bench for int16_to_fp16: directed corner cases plus randomized traffic,
// checked against an arithmetic reference model; honours INT16_TO_FP16_ROUND_EN.
module tb_int16_to_fp16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_inexact;

  typedef struct {
    logic [15:0] data;
    logic        inexact;
    int          issueCyc;
    logic        checkLat;
  } expItem_t;

  expItem_t    expQ[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  logic        checkLat = 1'b0;
  logic        randReady = 1'b0;
  logic        prevStalled = 1'b0;
  logic [15:0] prevData;
  logic        prevInexact;
  logic [15:0] rd;
  logic        rs;
  logic [16:0] rr;

  int16_to_fp16 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_signed  (in_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_inexact(out_inexact)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5 clk = 1'b1;
      cyc++;
      #5 clk = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: value = mag exactly; quantise to 11 significant bits with plain integer arithmetic.
  function automatic logic [16:0] refModel(input logic [15:0] d, input logic s);
    int   mag, e, q, rem, shift;
    logic neg;
    neg = s && d[15];
    mag = neg ? (65536 - int'(d)) : int'(d);
    if (mag == 0) return 17'd0;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    rem = 0;
    if (e <= 10) begin
      q = mag << (10 - e);
    end else begin
      shift = e - 10;
      q     = mag >> shift;
      rem   = mag - (q << shift);
`ifdef INT16_TO_FP16_ROUND_EN
      if (rem > (1 << (shift - 1)) || (rem == (1 << (shift - 1)) && (q % 2) == 1)) q++;
      if (q == 2048) begin
        q = 1024;
        e++;
      end
`endif
    end
    if (e + 15 >= 31) return {1'b1, neg, 5'd31, 10'd0};
    return {rem != 0, neg, 5'(e + 15), 10'(q - 1024)};
  endfunction

  // Drives one sample and holds it until accepted; records the expected result on acceptance.
  task automatic applyStimulus(input logic [15:0] d, input logic s, input logic [15:0] ed, input logic ei);
    int   waited = 0;
    logic done = 1'b0;
    in_data   = d;
    in_signed = s;
    in_valid  = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        expQ.push_back('{data: ed, inexact: ei, issueCyc: cyc, checkLat: checkLat});
        done = 1'b1;
      end else if (waited > 200) begin
        checkOutput("accept_timeout", 0, 1);
        done = 1'b1;
      end
      waited++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic applyModelled(input logic [15:0] d, input logic s);
    logic [16:0] r;
    r = refModel(d, s);
    applyStimulus(d, s, r[15:0], r[16]);
  endtask

  task automatic drain();
    int waited = 0;
    while (expQ.size() != 0 && waited < 500) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput("drain_remaining", expQ.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (randReady) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops one expectation per output transfer and checks stall stability.
  always @(negedge clk) begin
    expItem_t it;
    if (rst) begin
      prevStalled = 1'b0;
    end else begin
      if (prevStalled) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_data", out_data, prevData);
        checkOutput("hold_inexact", out_inexact, prevInexact);
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", out_data, 32'hFFFF_FFFF);
        end else begin
          it = expQ.pop_front();
          checkOutput("out_data", out_data, it.data);
          checkOutput("out_inexact", out_inexact, it.inexact);
          if (it.checkLat) checkOutput("latency", cyc - it.issueCyc, 3);
        end
      end
      prevStalled = out_valid && !out_ready;
      prevData    = out_data;
      prevInexact = out_inexact;
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_inexact", out_inexact, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] directed exact conversions");
    checkLat = 1'b1;
    applyStimulus(16'd1,      1'b0, 16'h3C00, 1'b0);
    applyStimulus(16'd1024,   1'b0, 16'h6400, 1'b0);
    applyStimulus(16'h8000,   1'b0, 16'h7800, 1'b0);
    applyStimulus(16'hFFFF,   1'b1, 16'hBC00, 1'b0);
    applyStimulus(16'h8000,   1'b1, 16'hF800, 1'b0);
    applyStimulus(16'h0000,   1'b1, 16'h0000, 1'b0);
`ifdef INT16_TO_FP16_ROUND_EN
    applyStimulus(16'd2049,   1'b0, 16'h6800, 1'b1);
    applyStimulus(16'd2051,   1'b0, 16'h6802, 1'b1);
    applyStimulus(16'd65519,  1'b0, 16'h7BFF, 1'b1);
    applyStimulus(16'd65520,  1'b0, 16'h7C00, 1'b1);
`else
    applyStimulus(16'd2051,   1'b0, 16'h6801, 1'b1);
    applyStimulus(16'd65535,  1'b0, 16'h7BFF, 1'b1);
`endif
    drain();
    checkLat = 1'b0;

    $display("[TB] stream of 8 with a 4-cycle output stall");
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          rd = 16'($urandom);
          rs = 1'($urandom);
          applyModelled(rd, rs);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          checkOutput("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] reset with samples in flight");
    out_ready = 1'b0;
    applyModelled(16'd100, 1'b0);
    applyModelled(16'd200, 1'b0);
    applyModelled(16'd300, 1'b0);
    rst = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_out_valid", out_valid, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    checkLat = 1'b1;
    applyStimulus(16'd3, 1'b0, 16'h4200, 1'b0);
    drain();
    checkLat = 1'b0;

    $display("[TB] randomized traffic");
    randReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      rd = 16'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(0, 9) == 0) rd = 16'($urandom_range(65500, 65535));
      applyModelled(rd, rs);
    end
    randReady = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/int16_to_fp16.md
INT16_TO_FP16 -- requirements
Module: int16_to_fp16

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  producer presents a sample on in_data/in_signed.
REQ-005 in_ready  output  1  block accepts the sample on this edge.
REQ-006 in_data  input  16  integer operand.
REQ-007 in_signed  input  1  1 = two's complement, 0 = unsigned.
REQ-008 out_valid  output  1  out_data/out_inexact hold a result.
REQ-009 out_ready  input  1  consumer takes the result on this edge.
REQ-010 out_data  output  16  IEEE 754 half-precision result: [15] sign, [14:10] exponent (bias 15), [9:0] fraction.
REQ-011 out_inexact  output  1  result does not exactly equal the input integer.

Function
REQ-012 The block SHALL be a 3-stage pipeline:
- S1: capture sign and magnitude; magnitude = |in_data| when in_signed, else in_data; range 0..65535.
- S2: leading-zero count, left-normalize, exponent = 15 + msb index (15..30).
- S3: round or truncate, then pack.
REQ-013 Transfers SHALL occur only on clock edges where valid and ready are both high; latency from input transfer to out_valid SHALL be 3 cycles with no stall.
REQ-014 The global advance SHALL be en = !out_valid || out_ready; all stages, including bubbles, SHALL shift only when en; in_ready SHALL equal en (0 while rst is high).
REQ-015 While out_valid=1 and out_ready=0, out_data, out_inexact and all stage contents SHALL hold; no sample is dropped or duplicated.
REQ-016 The block SHALL sustain full throughput of one result per cycle when out_ready stays high.
REQ-017 Zero input SHALL produce 0x0000 (never -0) with out_inexact=0.
REQ-018 Signed 0x8000 (-32768) SHALL produce 0xF800 exactly.
REQ-019 The fraction SHALL be the 10 bits below the leading 1; guard = the next bit; sticky = OR of all lower bits.
REQ-020 out_inexact SHALL be 1 when guard or sticky is 1, or when the result overflows to infinity.
REQ-021 Results SHALL never be NaN or subnormal; infinity (0x7C00/0xFC00) SHALL arise only from rounding per REQ-024.

Reset
REQ-022 On rst=1 at a clock edge, all stage-valid flags, out_valid, out_data and out_inexact SHALL clear to 0.
REQ-023 Reset asserted mid-operation SHALL discard every in-flight sample; the first result after reset SHALL come from the first sample accepted after rst deasserts.

Configuration
REQ-024 With macro INT16_TO_FP16_ROUND_EN defined, S3 SHALL round to nearest, ties to even; a mantissa carry-out SHALL increment the exponent, and an exponent of 31 SHALL produce signed infinity (unsigned inputs >= 65520 -> 0x7C00).
REQ-025 Without INT16_TO_FP16_ROUND_EN, S3 SHALL truncate; the result SHALL never overflow (65535 -> 0x7BFF); out_inexact behaves identically in both modes apart from overflow.

Verification
REQ-026 The bench SHALL cover these scenarios, each in both macro builds unless a build is named:
- Unsigned 1, 1024, 0x8000 -> 0x3C00, 0x6400, 0x7800; inexact=0; each out_valid exactly 3 cycles after its accept.
- Signed 0xFFFF, 0x8000, 0x0000 -> 0xBC00, 0xF800, 0x0000; inexact=0.
- ROUND_EN build, unsigned inputs:
  - 2049 -> 0x6800, inexact=1 (tie, even).
  - 2051 -> 0x6802, inexact=1.
  - 65519 -> 0x7BFF, inexact=1.
  - 65520 -> 0x7C00, inexact=1.
- Truncate build, unsigned inputs:
  - 2051 -> 0x6801, inexact=1.
  - 65535 -> 0x7BFF, inexact=1.
- Back-to-back stream of 8 samples with out_ready low for 4 cycles mid-stream -> in_ready low during the stall, outputs held stable, all 8 results in order with none lost.
- Assert rst for 1 cycle with 3 samples in flight -> out_valid=0 next cycle, no stale results emitted, and a new sample returns after 3 cycles.
